// File: rtl/cpu_seq_pkg.sv
// rtl/cpu_seq_pkg.sv - shared encodings for the CPU cycle sequencer
package cpu_seq_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    HALT  = 2'd2
  } seq_state_e;

  typedef enum logic [1:0] {
    INT_NONE = 2'd0,
    INT_RST  = 2'd1,
    INT_NMI  = 2'd2,
    INT_IRQ  = 2'd3
  } int_src_e;

  localparam logic [7:0] BRK_OPCODE = 8'h00;

endpackage

// File: rtl/phi_clock_gen.sv
// rtl/phi_clock_gen.sv - sys_clock divider producing the phi2 level and clk_ph2 boundary strobe
module phi_clock_gen #(
  parameter int PHI_DIV = 12
) (
  input  logic sys_clock,
  input  logic rst,
  output logic phi2,
  output logic clk_ph2
);

  localparam int CNT_W = $clog2(PHI_DIV);

  logic [CNT_W-1:0] div_cnt_q, div_cnt_d;

  always_comb begin
    div_cnt_d = div_cnt_q + 1'b1;
    if (div_cnt_q == CNT_W'(PHI_DIV - 1)) begin
      div_cnt_d = '0;
    end
  end

  always_ff @(posedge sys_clock or posedge rst) begin
    if (rst) begin
      div_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
    end
  end

  // Decoded straight from the count so the strobe lines up with the boundary posedge.
  assign phi2    = (div_cnt_q >= CNT_W'(PHI_DIV / 2));
  assign clk_ph2 = (div_cnt_q == CNT_W'(PHI_DIV - 1));

endmodule

// File: rtl/cpu_cycle_sequencer.sv
// rtl/cpu_cycle_sequencer.sv - opcode fetch, cycle counter and interrupt arbitration for the decoder
// Define SEQ_HALT_EN to make cycle overflow sticky (decode_err) and park in HALT.
import cpu_seq_pkg::*;

module cpu_cycle_sequencer #(
  parameter int PHI_DIV = 12,
  parameter int CYCLE_W = 3
) (
  input  logic               sys_clock,
  input  logic               rst,
  input  logic               rdy,
  input  logic               rw,
  input  logic               last_cycle,
  input  logic               nmi_n,
  input  logic               irq_n,
  input  logic               i_flag,
  input  logic [7:0]         data_in,
  output logic               phi2,
  output logic               clk_ph2,
  output logic [CYCLE_W-1:0] cycle,
  output logic [7:0]         IR,
  output logic               sync,
  output logic [1:0]         int_src,
  output logic               decode_err
);

  seq_state_e         state_q, state_d;
  logic [CYCLE_W-1:0] cycle_q, cycle_d;
  logic [7:0]         ir_q, ir_d;
  int_src_e           int_src_q, int_src_d;
  logic               sync_q, sync_d;
  logic               rst_pend_q, rst_pend_d;
  logic               nmi_pend_q, nmi_pend_d;
  logic               nmi_prev_q, nmi_prev_d;
  logic               stall;
  logic               boundary;
`ifdef SEQ_HALT_EN
  logic               err_q, err_d;
`endif

  phi_clock_gen #(.PHI_DIV(PHI_DIV)) u_phi_clock_gen (
    .sys_clock (sys_clock),
    .rst       (rst),
    .phi2      (phi2),
    .clk_ph2   (clk_ph2)
  );

  assign boundary = clk_ph2;
  // Writes never wait on rdy; only read cycles stretch.
  assign stall    = ~rdy & rw;

  always_comb begin
    state_d    = state_q;
    cycle_d    = cycle_q;
    ir_d       = ir_q;
    int_src_d  = int_src_q;
    sync_d     = sync_q;
    rst_pend_d = rst_pend_q;
    nmi_pend_d = nmi_pend_q;
    nmi_prev_d = nmi_prev_q;
`ifdef SEQ_HALT_EN
    err_d      = err_q;
`endif
    if (boundary) begin
      nmi_prev_d = nmi_n;
      if (!stall) begin
        case (state_q)
          FETCH: begin
            cycle_d = '0;
            state_d = EXEC;
            sync_d  = 1'b0;
            if (rst_pend_q) begin
              ir_d       = BRK_OPCODE;
              int_src_d  = INT_RST;
              rst_pend_d = 1'b0;
            end else if (nmi_pend_q) begin
              ir_d       = BRK_OPCODE;
              int_src_d  = INT_NMI;
              nmi_pend_d = 1'b0;
            end else if (!irq_n && !i_flag) begin
              ir_d      = BRK_OPCODE;
              int_src_d = INT_IRQ;
            end else begin
              ir_d      = data_in;
              int_src_d = INT_NONE;
            end
          end
          EXEC: begin
            if (last_cycle) begin
              state_d = FETCH;
              cycle_d = '0;
              sync_d  = 1'b1;
            end else if (cycle_q != '1) begin
              cycle_d = cycle_q + 1'b1;
            end else begin
`ifdef SEQ_HALT_EN
              state_d = HALT;
              err_d   = 1'b1;
              sync_d  = 1'b0;
`else
              state_d = FETCH;
              cycle_d = '0;
              sync_d  = 1'b1;
`endif
            end
          end
`ifdef SEQ_HALT_EN
          HALT: begin
          end
`endif
          default: begin
            state_d = FETCH;
          end
        endcase
      end
      // A fresh edge outranks a service on the same boundary.
      if (nmi_prev_q && !nmi_n) begin
        nmi_pend_d = 1'b1;
      end
    end
  end

  always_ff @(posedge sys_clock or posedge rst) begin
    if (rst) begin
      state_q    <= FETCH;
      cycle_q    <= '0;
      ir_q       <= BRK_OPCODE;
      int_src_q  <= INT_NONE;
      sync_q     <= 1'b0;
      rst_pend_q <= 1'b1;
      nmi_pend_q <= 1'b0;
      nmi_prev_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      cycle_q    <= cycle_d;
      ir_q       <= ir_d;
      int_src_q  <= int_src_d;
      sync_q     <= sync_d;
      rst_pend_q <= rst_pend_d;
      nmi_pend_q <= nmi_pend_d;
      nmi_prev_q <= nmi_prev_d;
    end
  end

`ifdef SEQ_HALT_EN
  always_ff @(posedge sys_clock or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign decode_err = err_q;
`else
  assign decode_err = 1'b0;
`endif

  assign cycle   = cycle_q;
  assign IR      = ir_q;
  assign int_src = int_src_q;
  assign sync    = sync_q;

endmodule

// File: tb/tb_cpu_cycle_sequencer.sv
// tb/tb_cpu_cycle_sequencer.sv - directed self-checking bench for cpu_cycle_sequencer
module tb_cpu_cycle_sequencer;

  localparam int PHI_DIV = 12;
  localparam int CYCLE_W = 3;

  logic               sys_clock;
  logic               rst;
  logic               rdy;
  logic               rw;
  logic               last_cycle;
  logic               nmi_n;
  logic               irq_n;
  logic               i_flag;
  logic [7:0]         data_in;
  logic               phi2;
  logic               clk_ph2;
  logic [CYCLE_W-1:0] cycle;
  logic [7:0]         IR;
  logic               sync;
  logic [1:0]         int_src;
  logic               decode_err;

  int n_checks;
  int n_pass;
  int phi_hi;

  cpu_cycle_sequencer #(.PHI_DIV(PHI_DIV), .CYCLE_W(CYCLE_W)) dut (
    .sys_clock  (sys_clock),
    .rst        (rst),
    .rdy        (rdy),
    .rw         (rw),
    .last_cycle (last_cycle),
    .nmi_n      (nmi_n),
    .irq_n      (irq_n),
    .i_flag     (i_flag),
    .data_in    (data_in),
    .phi2       (phi2),
    .clk_ph2    (clk_ph2),
    .cycle      (cycle),
    .IR         (IR),
    .sync       (sync),
    .int_src    (int_src),
    .decode_err (decode_err)
  );

  initial sys_clock = 1'b0;
  always #5 sys_clock = ~sys_clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  // Called at a negedge; returns at the negedge just after the next boundary posedge.
  task automatic next_boundary();
    int n;
    n = 0;
    while (clk_ph2 !== 1'b1 && n < 3 * PHI_DIV) begin
      @(negedge sys_clock);
      n++;
    end
    if (clk_ph2 !== 1'b1) begin
      check("boundary_timeout", 32'(clk_ph2), 32'd1);
    end
    @(negedge sys_clock);
  endtask

  task automatic finish_and_fetch();
    last_cycle = 1'b1;
    next_boundary();
    last_cycle = 1'b0;
    next_boundary();
  endtask

  initial begin
    n_checks   = 0;
    n_pass     = 0;
    rst        = 1'b1;
    rdy        = 1'b1;
    rw         = 1'b1;
    last_cycle = 1'b0;
    nmi_n      = 1'b1;
    irq_n      = 1'b1;
    i_flag     = 1'b1;
    data_in    = 8'hA9;

    repeat (3) @(negedge sys_clock);
    check("rst_phi2", 32'(phi2), 32'd0);
    check("rst_clk_ph2", 32'(clk_ph2), 32'd0);
    check("rst_cycle", 32'(cycle), 32'd0);
    check("rst_ir", 32'(IR), 32'h00);
    check("rst_int_src", 32'(int_src), 32'd0);
    check("rst_sync", 32'(sync), 32'd0);
    check("rst_decode_err", 32'(decode_err), 32'd0);

    // Divider: strobe only before posedges 12, 24, 36; phi2 high half the time.
    rst = 1'b0;
    phi_hi = 0;
    for (int k = 1; k <= 36; k++) begin
      check("div_clk_ph2", 32'(clk_ph2), 32'((k % 12) == 0));
      if (phi2) phi_hi++;
      @(negedge sys_clock);
    end
    check("div_phi2_high", 32'(phi_hi), 32'd18);

    // Reset sequence from a fresh release.
    rst = 1'b1;
    @(negedge sys_clock);
    rst = 1'b0;
    next_boundary();
    check("rstseq_ir", 32'(IR), 32'h00);
    check("rstseq_int_src", 32'(int_src), 32'd1);
    check("rstseq_sync", 32'(sync), 32'd0);
    last_cycle = 1'b1;
    next_boundary();
    check("rstseq_to_fetch_sync", 32'(sync), 32'd1);
    last_cycle = 1'b0;
    next_boundary();
    check("fetch_ir", 32'(IR), 32'hA9);
    check("fetch_int_src", 32'(int_src), 32'd0);
    check("fetch_cycle", 32'(cycle), 32'd0);

    // Stall in EXEC cycle 2, then rw=0 ignores rdy.
    next_boundary();
    next_boundary();
    check("pre_stall_cycle", 32'(cycle), 32'd2);
    rdy = 1'b0;
    rw  = 1'b1;
    for (int b = 0; b < 3; b++) begin
      next_boundary();
      check("stall_cycle", 32'(cycle), 32'd2);
    end
    rw = 1'b0;
    next_boundary();
    check("write_nostall_cycle", 32'(cycle), 32'd3);

    // NMI edge arriving while stalled is still captured.
    rw    = 1'b1;
    nmi_n = 1'b0;
    next_boundary();
    check("nmi_stall_cycle", 32'(cycle), 32'd3);
    next_boundary();
    rdy = 1'b1;
    finish_and_fetch();
    check("nmi_stall_int_src", 32'(int_src), 32'd2);
    check("nmi_stall_ir", 32'(IR), 32'h00);
    data_in = 8'h4C;
    finish_and_fetch();
    check("nmi_no_retrigger_int_src", 32'(int_src), 32'd0);
    check("nmi_no_retrigger_ir", 32'(IR), 32'h4C);

    // NMI outranks IRQ; IRQ then taken; masked IRQ ignored.
    nmi_n = 1'b1;
    next_boundary();
    nmi_n      = 1'b0;
    irq_n      = 1'b0;
    i_flag     = 1'b0;
    last_cycle = 1'b1;
    next_boundary();
    last_cycle = 1'b0;
    next_boundary();
    check("prio_nmi_int_src", 32'(int_src), 32'd2);
    finish_and_fetch();
    check("prio_irq_int_src", 32'(int_src), 32'd3);
    check("prio_irq_ir", 32'(IR), 32'h00);
    i_flag  = 1'b1;
    data_in = 8'hEA;
    finish_and_fetch();
    check("irq_masked_int_src", 32'(int_src), 32'd0);
    check("irq_masked_ir", 32'(IR), 32'hEA);
    irq_n = 1'b1;
    nmi_n = 1'b1;

    // Overflow: count to 7 with no last_cycle, then one more boundary.
    for (int b = 0; b < 7; b++) next_boundary();
    check("ovf_cycle_max", 32'(cycle), 32'd7);
    next_boundary();
`ifdef SEQ_HALT_EN
    check("ovf_decode_err", 32'(decode_err), 32'd1);
    check("ovf_halt_cycle", 32'(cycle), 32'd7);
    check("ovf_halt_sync", 32'(sync), 32'd0);
    finish_and_fetch();
    check("halt_frozen_cycle", 32'(cycle), 32'd7);
    check("halt_frozen_ir", 32'(IR), 32'hEA);
`else
    check("ovf_decode_err", 32'(decode_err), 32'd0);
    check("ovf_wrap_cycle", 32'(cycle), 32'd0);
    check("ovf_wrap_sync", 32'(sync), 32'd1);
    next_boundary();
`endif

    // Asynchronous reset mid-instruction, no clock edge needed.
    @(negedge sys_clock);
    #2 rst = 1'b1;
    #1;
    check("async_rst_cycle", 32'(cycle), 32'd0);
    check("async_rst_ir", 32'(IR), 32'h00);
    check("async_rst_int_src", 32'(int_src), 32'd0);
    check("async_rst_decode_err", 32'(decode_err), 32'd0);
    check("async_rst_clk_ph2", 32'(clk_ph2), 32'd0);
    @(negedge sys_clock);
    rst = 1'b0;
    next_boundary();
    check("post_abort_int_src", 32'(int_src), 32'd1);
    check("post_abort_ir", 32'(IR), 32'h00);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/cpu_cycle_sequencer.md
Name: cpu_cycle_sequencer

Overview:
- Sequences the CPU's instruction decoder.
- Generates the CPU phase timing from sys_clock: the phi2 level and the one-sys_clock clk_ph2 strobe the decoder samples.
- Owns the opcode fetch into IR and the per-instruction cycle counter.
- Arbitrates between reset, NMI, IRQ and normal fetch, and injects BRK (8'h00) for interrupt sequences.
- Sits between the bus interface and instruction_decoder; the decoder consumes cycle, IR, clk_ph2 and int_src.

Parameters:
- PHI_DIV, 12, sys_clock cycles per CPU cycle; even, at least 4.
- CYCLE_W, 3, width of the cycle counter.

Ports:
- sys_clock  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high.
- rdy  in  1  bus ready; low stalls read cycles only.
- rw  in  1  current bus cycle is a read (1) or a write (0).
- last_cycle  in  1  decoder flag: the current EXEC cycle is the final cycle of the instruction.
- nmi_n  in  1  NMI request, falling-edge sensitive.
- irq_n  in  1  IRQ request, level sensitive, active-low.
- i_flag  in  1  processor-status interrupt-disable flag.
- data_in  in  8  data bus read value.
- phi2  out  1  phase-2 level.
- clk_ph2  out  1  single-sys_clock strobe marking the CPU cycle boundary.
- cycle  out  CYCLE_W  current instruction cycle.
- IR  out  8  instruction register.
- sync  out  1  current CPU cycle is an opcode fetch.
- int_src  out  2  source of the BRK in IR: 0 none, 1 reset, 2 NMI, 3 IRQ.
- decode_err  out  1  sticky error: cycle overflow.

Behaviour:
- Reset (rst=1, asynchronous): div_cnt=0, phi2=0, clk_ph2=0, state=FETCH, cycle=0, IR=8'h00, int_src=0, sync=0, decode_err=0, rst_pend=1, nmi_pend=0, nmi_prev=1.
- Divider:
  - div_cnt counts 0..PHI_DIV-1 and wraps.
  - phi2=1 while div_cnt >= PHI_DIV/2.
  - clk_ph2=1 only when div_cnt==PHI_DIV-1. This is the "boundary".
  - After rst falls, the first boundary occurs on the PHI_DIV-th posedge.
- Boundary processing:
  - All state, cycle, IR and int_src updates happen only on boundary posedges.
  - Everything except the divider updates is registered and becomes visible on the following sys_clock.
- Stall: at a boundary with rdy=0 and rw=1, state, cycle, IR, int_src and sync hold. The divider and NMI edge detection keep running. rdy is ignored when rw=0.
- NMI detection: at every boundary, nmi_prev<=nmi_n. If nmi_prev=1 and nmi_n=0, set nmi_pend. If a set and a clear land on the same boundary, the set wins.
- FETCH state (sync=1), at a non-stalled boundary, priority rst_pend > nmi_pend > IRQ:
  - rst_pend: IR<=8'h00, int_src<=1, clear rst_pend.
  - nmi_pend: IR<=8'h00, int_src<=2, clear nmi_pend.
  - IRQ (irq_n=0 and i_flag=0, sampled at this boundary): IR<=8'h00, int_src<=3.
  - Otherwise: IR<=data_in, int_src<=0.
  - In every case: cycle<=0, go to EXEC.
- EXEC state (sync=0), at a non-stalled boundary:
  - last_cycle=1: go to FETCH, cycle<=0. IR holds until the next fetch.
  - Otherwise, cycle<2^CYCLE_W-1: cycle<=cycle+1.
  - Otherwise (cycle at max, no last_cycle): overflow; handling is defined under Optional Feature.
- HALT state: sync=0, cycle and IR frozen. Left only by rst.
- Reset asserted mid-instruction: aborts immediately to reset values. The first fetch after release services the reset (int_src=1).

Optional Feature:
- Macro: SEQ_HALT_EN.
- Defined: cycle overflow sets decode_err=1 (sticky until rst) and enters HALT.
- Undefined: overflow wraps cycle to 0 and forces state FETCH; decode_err is tied to 0 and there is no HALT state.

Decomposition:
- Package cpu_seq_pkg holds:
  - state encoding: FETCH, EXEC, HALT;
  - int_src codes: INT_NONE, INT_RST, INT_NMI, INT_IRQ;
  - BRK_OPCODE=8'h00.
- Sub-module phi_clock_gen holds the divider and produces phi2 and clk_ph2. The sequencer FSM stays in the top.

Test Plan:
- Divider: release rst, PHI_DIV=12 -> clk_ph2 pulses on posedges 12, 24, 36; each pulse is 1 sys_clock wide; phi2 high for 6 of every 12.
- Reset sequence: release rst, data_in=8'hA9 -> first fetch gives IR=8'h00, int_src=1; after last_cycle, the next fetch gives IR=8'hA9, int_src=0, cycle=0.
- Stall: hold rdy=0, rw=1 in EXEC cycle 2 for 3 boundaries -> cycle stays 2; rdy=0, rw=0 -> cycle advances to 3.
- Interrupt priority: nmi_n falls and irq_n=0, i_flag=0 before a fetch -> int_src=2 first; the following fetch gives int_src=3; with i_flag=1, the IRQ is ignored and IR=data_in.
- NMI edge during stall: nmi_n falls while stalled -> nmi_pend is captured; the next fetch gives int_src=2. Holding nmi_n low does not retrigger.
- Overflow: never assert last_cycle, CYCLE_W=3 -> with SEQ_HALT_EN, decode_err=1 after cycle 7 and cycle stays 7 (HALT); without it, cycle wraps to 0 and sync=1.
